// File: rtl/cv32e41p_pkg.sv
// Shared types and helpers for the instruction-side OBI responder.
// Holds the queued response entry type and the saturating age arithmetic.
package cv32e41p_pkg;

  localparam int unsigned RESP_AGE_W = 4;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_instr_resp_t;

  function automatic logic [RESP_AGE_W-1:0] age_sat_inc(input logic [RESP_AGE_W-1:0] age);
    return (&age) ? age : age + RESP_AGE_W'(1);
  endfunction

endpackage

// File: rtl/cv32e41p_obi_resp_fifo.sv
// In-order response queue with per-entry age counters and a head-eligibility flag.
// An empty queue lets a same-cycle push act as the head, so the minimum latency is one cycle.
module cv32e41p_obi_resp_fifo
  import cv32e41p_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned MIN_AGE = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  obi_instr_resp_t push_data_i,
  input  logic            hold_i,
  input  logic            pop_i,
  output obi_instr_resp_t head_o,
  output logic            head_eligible_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  obi_instr_resp_t       ent_q [DEPTH];
  obi_instr_resp_t       ent_d [DEPTH];
  logic [RESP_AGE_W-1:0] age_q [DEPTH];
  logic [RESP_AGE_W-1:0] age_d [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  empty;
  logic                  do_write;
  logic                  do_read;
  logic [RESP_AGE_W-1:0] head_age;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign empty    = (count_q == '0);
  assign do_write = push_i & ~(empty & pop_i);
  assign do_read  = pop_i & ~empty;

  // Head age is the value it will have at the coming edge; a bypassed push is age 0.
  always_comb begin
    head_o          = empty ? push_data_i : ent_q[rd_ptr_q];
    head_age        = empty ? '0 : age_sat_inc(age_q[rd_ptr_q]);
    head_eligible_o = (push_i | ~empty) & ~hold_i &
                      (({1'b0, head_age} + (RESP_AGE_W+1)'(1)) > (RESP_AGE_W+1)'(MIN_AGE));
  end

  always_comb begin
    ent_d    = ent_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      age_d[i] = age_sat_inc(age_q[i]);
    end
    if (do_write) begin
      ent_d[wr_ptr_q] = push_data_i;
      age_d[wr_ptr_q] = '0;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_read) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    count_d = count_q + CNT_W'(do_write) - CNT_W'(do_read);
  end

  always_ff @(posedge clk) begin
    ent_q <= ent_d;
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      age_q    <= age_d;
    end
  end

endmodule

// File: rtl/cv32e41p_instr_obi_responder.sv
// Instruction-side OBI memory model: grants fetches, reads a word array at grant time
// and returns in-order responses with programmable latency and stalls.
module cv32e41p_instr_obi_responder
  import cv32e41p_pkg::*;
#(
  parameter int unsigned MEM_WORDS       = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned RESP_LATENCY    = 1,
  localparam int unsigned MEM_AW         = $clog2(MEM_WORDS),
  localparam int unsigned OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_req_i,
  input  logic [31:0]       instr_addr_i,
  output logic              instr_gnt_o,
  output logic              instr_rvalid_o,
  output logic [31:0]       instr_rdata_o,
  output logic              instr_err_o,
  input  logic              gnt_stall_i,
  input  logic              rvalid_stall_i,
  input  logic              load_we_i,
  input  logic [MEM_AW-1:0] load_addr_i,
  input  logic [31:0]       load_wdata_i,
  output logic [OUT_W-1:0]  outstanding_o,
  output logic              busy_o
);

  logic [31:0]     mem_q [MEM_WORDS];
  logic [31:0]     addr_off;
  logic            addr_below_base;
  logic            in_range;
  logic            unused_addr_lsb;
  obi_instr_resp_t fetch_resp;
  obi_instr_resp_t head;
  logic            head_eligible;

  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic             rvalid_q, rvalid_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  // The borrow of the offset subtraction doubles as the "below BASE_ADDR" test.
  assign {addr_below_base, addr_off} = {1'b0, instr_addr_i} - {1'b0, BASE_ADDR};
  assign in_range        = ~addr_below_base & (addr_off[31:2] < 30'(MEM_WORDS));
  assign unused_addr_lsb = ^addr_off[1:0];

  always_comb begin
    fetch_resp.rdata = '0;
    fetch_resp.err   = 1'b1;
    if (in_range) begin
      fetch_resp.rdata = mem_q[addr_off[MEM_AW+1:2]];
      fetch_resp.err   = 1'b0;
    end
  end

  // A response leaving the output register this cycle frees its slot immediately.
  assign instr_gnt_o = instr_req_i & ~gnt_stall_i & ~load_we_i &
                       ((outstanding_q - OUT_W'(rvalid_q)) < OUT_W'(MAX_OUTSTANDING));

  cv32e41p_obi_resp_fifo #(
    .DEPTH   (MAX_OUTSTANDING),
    .MIN_AGE (RESP_LATENCY - 1)
  ) u_resp_fifo (
    .clk             (clk),
    .rst             (rst),
    .push_i          (instr_gnt_o),
    .push_data_i     (fetch_resp),
    .hold_i          (rvalid_stall_i),
    .pop_i           (head_eligible),
    .head_o          (head),
    .head_eligible_o (head_eligible)
  );

  always_comb begin
    outstanding_d = outstanding_q + OUT_W'(instr_gnt_o) - OUT_W'(rvalid_q);
    rvalid_d      = head_eligible;
    rdata_d       = head_eligible ? head.rdata : '0;
    err_d         = head_eligible & head.err;
  end

  always_ff @(posedge clk) begin
    if (load_we_i) begin
      mem_q[load_addr_i] <= load_wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding_q <= '0;
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      rvalid_q      <= rvalid_d;
      rdata_q       <= rdata_d;
      err_q         <= err_d;
    end
  end

  assign instr_rvalid_o = rvalid_q;
  assign instr_rdata_o  = rdata_q;
  assign instr_err_o    = err_q;
  assign outstanding_o  = outstanding_q;
  assign busy_o         = |outstanding_q;

endmodule
